fetch_unit: RTL and testbench

Instruction fetch stage of the RV32I core, directly upstream of `control_unit`. Holds the program counter, requests instruction words from instruction memory over a req/gnt/rvalid handshake, and presents a stable `instruction`/`pc` pair to the decode and datapath logic until the core signals completion. On completion it selects the next PC from `pc_sel`: either sequential PC+4 or the ALU-computed jump/branch target.

---
 rtl/package_param.sv | 14 +
 rtl/pc_next_gen.sv | 26 ++
 rtl/fetch_unit.sv | 133 +++++++++++++
 tb/tb_fetch_unit.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/package_param.sv
// Shared types and constants for the instruction fetch stage.
package package_param;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    WAIT,
    VALID,
    TRAP
  } fetch_state_e;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

endpackage

// File: rtl/pc_next_gen.sv
// Next-PC selection: sequential PC+4 or jump/branch target, with alignment handling.
// FETCH_MISALIGN_TRAP_EN keeps bit 1 and reports it; otherwise the target is word-aligned.
module pc_next_gen (
  input  logic [31:0] pc,
  input  logic        pc_sel,
  input  logic [31:0] alu_data,
  output logic [31:0] pc_four,
  output logic [31:0] next_pc,
  output logic        misalign
);

  logic [31:0] target;

  always_comb begin
    pc_four = pc + 32'd4;
    target  = pc_sel ? (alu_data & 32'hFFFF_FFFE) : pc_four;
`ifdef FETCH_MISALIGN_TRAP_EN
    next_pc  = target;
    misalign = target[1];
`else
    next_pc  = target & 32'hFFFF_FFFC;
    misalign = 1'b0;
`endif
  end

endmodule

// File: rtl/fetch_unit.sv
// RV32I fetch stage: PC register, imem req/gnt/rvalid handshake, held instruction/pc pair.
// FETCH_MISALIGN_TRAP_EN adds a sticky TRAP state on a misaligned next PC.
//
// state | meaning
// IDLE  | one cycle after reset before the first request
// REQ   | imem_req high, waiting for imem_gnt
// WAIT  | request accepted, waiting for imem_rvalid
// VALID | instruction/pc presented, waiting for instr_done
// TRAP  | misaligned target seen; frozen until reset
module fetch_unit
  import package_param::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        instr_done,
  input  logic        pc_sel,
  input  logic [31:0] alu_data,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instruction,
  output logic        instr_valid,
  output logic [31:0] pc,
  output logic [31:0] pc_four,
  output logic        fetch_misalign
);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  instr_q, instr_d;
  logic         valid_q, valid_d;
  logic         req_q, req_d;
  logic         misalign_q, misalign_d;
  logic [31:0]  next_pc;
  logic         next_misalign;

  pc_next_gen u_pc_next_gen (
    .pc       (pc_q),
    .pc_sel   (pc_sel),
    .alu_data (alu_data),
    .pc_four  (pc_four),
    .next_pc  (next_pc),
    .misalign (next_misalign)
  );

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    instr_d    = instr_q;
    valid_d    = valid_q;
    req_d      = req_q;
    misalign_d = misalign_q;
    case (state_q)
      IDLE: begin
        state_d = REQ;
        req_d   = 1'b1;
      end
      REQ: begin
        if (imem_gnt) begin
          state_d = WAIT;
          req_d   = 1'b0;
        end
      end
      WAIT: begin
        if (imem_rvalid) begin
          state_d = VALID;
          instr_d = imem_rdata;
          valid_d = 1'b1;
        end
      end
      VALID: begin
        if (instr_done) begin
          pc_d    = next_pc;
          valid_d = 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
          if (next_misalign) begin
            state_d    = TRAP;
            misalign_d = 1'b1;
          end else begin
            state_d = REQ;
            req_d   = 1'b1;
          end
`else
          state_d    = REQ;
          req_d      = 1'b1;
          misalign_d = misalign_q | next_misalign;
`endif
        end
      end
`ifdef FETCH_MISALIGN_TRAP_EN
      TRAP: begin
        req_d   = 1'b0;
        valid_d = 1'b0;
      end
`endif
      default: begin
        state_d = IDLE;
        req_d   = 1'b0;
        valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      pc_q       <= RESET_PC;
      instr_q    <= NOP_INSTR;
      valid_q    <= 1'b0;
      req_q      <= 1'b0;
      misalign_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      instr_q    <= instr_d;
      valid_q    <= valid_d;
      req_q      <= req_d;
      misalign_q <= misalign_d;
    end
  end

  assign imem_req       = req_q;
  assign imem_addr      = pc_q;
  assign pc             = pc_q;
  assign instruction    = instr_q;
  assign instr_valid    = valid_q;
  assign fetch_misalign = misalign_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: transaction-level model of PC flow plus per-cycle compare.
module tb_fetch_unit;

  localparam logic [31:0] RST_PC = 32'h0000_0000;
  localparam logic [31:0] NOP    = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        instr_done = 1'b0;
  logic        pc_sel = 1'b0;
  logic [31:0] alu_data = 32'h0;
  logic        imem_gnt = 1'b0;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = 32'h0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] instruction;
  logic        instr_valid;
  logic [31:0] pc;
  logic [31:0] pc_four;
  logic        fetch_misalign;

  fetch_unit #(.RESET_PC(RST_PC)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .instr_done     (instr_done),
    .pc_sel         (pc_sel),
    .alu_data       (alu_data),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_gnt       (imem_gnt),
    .imem_rvalid    (imem_rvalid),
    .imem_rdata     (imem_rdata),
    .instruction    (instruction),
    .instr_valid    (instr_valid),
    .pc             (pc),
    .pc_four        (pc_four),
    .fetch_misalign (fetch_misalign)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Model state: PC the fetch stage must currently hold, and expected handshake outputs.
  logic [31:0] model_pc = RST_PC;
  logic        exp_valid = 1'b0;
  logic        exp_req = 1'b0;
  logic        exp_mis = 1'b0;
  logic        cmp_en = 1'b0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0) return 32'h0050_0093;
    return (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
  endfunction

  function automatic logic [31:0] next_of(input logic [31:0] cur, input logic sel,
                                          input logic [31:0] alu);
    logic [31:0] n;
    n = sel ? (alu & 32'hFFFF_FFFE) : cur + 32'd4;
`ifndef FETCH_MISALIGN_TRAP_EN
    n = n & 32'hFFFF_FFFC;
`endif
    return n;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("imem_addr", imem_addr, model_pc);
      chk("pc", pc, model_pc);
      chk("pc_four", pc_four, model_pc + 32'd4);
      chk1("imem_req", imem_req, exp_req);
      chk1("instr_valid", instr_valid, exp_valid);
      chk1("fetch_misalign", fetch_misalign, exp_mis);
      if (exp_valid) chk("instruction", instruction, mem_word(model_pc));
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic do_grant(input int gd);
    repeat (gd) begin
      imem_gnt   = 1'b0;
      instr_done = 1'($urandom);
      step();
    end
    imem_gnt   = 1'b1;
    instr_done = 1'($urandom);
    exp_req    = 1'b0;
    step();
    imem_gnt = 1'b0;
  endtask

  task automatic do_data(input int rd);
    repeat (rd) begin
      imem_rvalid = 1'b0;
      imem_rdata  = $urandom;
      instr_done  = 1'($urandom);
      step();
    end
    imem_rvalid = 1'b1;
    imem_rdata  = mem_word(model_pc);
    instr_done  = 1'($urandom);
    exp_valid   = 1'b1;
    step();
    imem_rvalid = 1'b0;
    instr_done  = 1'b0;
  endtask

  task automatic do_done(input int dd, input logic sel, input logic [31:0] alu, input logic junk);
    logic [31:0] n;
    repeat (dd) begin
      instr_done  = 1'b0;
      imem_rvalid = junk ? 1'($urandom) : 1'b0;
      imem_rdata  = $urandom;
      step();
    end
    imem_rvalid = 1'b0;
    instr_done  = 1'b1;
    pc_sel      = sel;
    alu_data    = alu;
    n           = next_of(model_pc, sel, alu);
    model_pc    = n;
    exp_valid   = 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
    if (n[1]) begin
      exp_mis = 1'b1;
      exp_req = 1'b0;
    end else begin
      exp_req = 1'b1;
    end
`else
    exp_req = 1'b1;
`endif
    step();
    instr_done = 1'b0;
    pc_sel     = 1'($urandom);
    alu_data   = $urandom;
  endtask

  initial begin
    repeat (3) step();
    rst_n     = 1'b1;
    model_pc  = RST_PC;
    exp_valid = 1'b0;
    exp_mis   = 1'b0;
    exp_req   = 1'b1;
    chk1("reset_req", imem_req, 1'b0);
    chk1("reset_valid", instr_valid, 1'b0);
    chk1("reset_mis", fetch_misalign, 1'b0);
    chk("reset_instr", instruction, NOP);
    chk("reset_addr", imem_addr, RST_PC);
    cmp_en = 1'b1;
    step();
    chk1("first_req", imem_req, 1'b1);

    // first fetch: zero-wait grant, rvalid one cycle later
    do_grant(0);
    do_data(0);
    chk1("first_valid", instr_valid, 1'b1);
    chk("first_instr", instruction, 32'h0050_0093);
    chk("first_pc", pc, 32'h0);
    chk("first_pc_four", pc_four, 32'h4);
    do_done(0, 1'b0, 32'h0, 1'b0);
    chk("seq_addr", imem_addr, 32'h4);

    do_grant(0);
    do_data(0);
    do_done(1, 1'b1, 32'h0000_0101, 1'b1);
    chk("jump_addr", imem_addr, 32'h0000_0100);

    // grant withheld for 3 cycles
    do_grant(3);
    chk1("granted_req_low", imem_req, 1'b0);
    do_data(2);
    do_done(0, 1'b0, 32'h0, 1'b0);
    chk("after_stall_addr", imem_addr, 32'h0000_0104);

    // wrap-around from the top of the address space
    do_grant(1);
    do_data(0);
    do_done(0, 1'b1, 32'hFFFF_FFFD, 1'b0);
    chk("top_addr", imem_addr, 32'hFFFF_FFFC);
    do_grant(0);
    do_data(1);
    do_done(0, 1'b0, 32'h0, 1'b0);
    chk("wrap_addr", imem_addr, 32'h0);

    // asynchronous reset while waiting for rvalid, then a stale response
    do_grant(0);
    cmp_en = 1'b0;
    rst_n  = 1'b0;
    #1;
    chk1("async_rst_req", imem_req, 1'b0);
    chk1("async_rst_valid", instr_valid, 1'b0);
    chk("async_rst_addr", imem_addr, RST_PC);
    chk("async_rst_instr", instruction, NOP);
    step();
    rst_n       = 1'b1;
    model_pc    = RST_PC;
    exp_valid   = 1'b0;
    exp_req     = 1'b1;
    exp_mis     = 1'b0;
    cmp_en      = 1'b1;
    imem_rvalid = 1'b1;
    imem_rdata  = 32'hDEAD_BEEF;
    repeat (3) step();
    imem_rvalid = 1'b0;
    chk("stale_instr", instruction, NOP);
    chk1("stale_valid", instr_valid, 1'b0);
    chk("stale_addr", imem_addr, RST_PC);

    for (int i = 0; i < 40; i++) begin
      logic [31:0] alu;
      alu = $urandom;
`ifdef FETCH_MISALIGN_TRAP_EN
      alu = alu & 32'hFFFF_FFFD;
`endif
      do_grant(int'($urandom_range(0, 3)));
      do_data(int'($urandom_range(0, 3)));
      do_done(int'($urandom_range(0, 3)), 1'($urandom), alu, 1'b1);
    end

    // misaligned jump target
    do_grant(0);
    do_data(0);
    do_done(0, 1'b1, 32'h0000_0102, 1'b0);
`ifdef FETCH_MISALIGN_TRAP_EN
    chk1("trap_mis", fetch_misalign, 1'b1);
    chk("trap_pc", pc, 32'h0000_0102);
    repeat (5) begin
      imem_gnt    = 1'($urandom);
      imem_rvalid = 1'($urandom);
      instr_done  = 1'($urandom);
      step();
    end
    chk1("trap_req", imem_req, 1'b0);
    chk1("trap_valid", instr_valid, 1'b0);
`else
    chk("align_addr", imem_addr, 32'h0000_0100);
    chk1("align_mis", fetch_misalign, 1'b0);
`endif
    imem_gnt    = 1'b0;
    imem_rvalid = 1'b0;
    instr_done  = 1'b0;
    repeat (2) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
